// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder/comparator among NUM_REQ requesters,
// with bounded carry-chain locking and private per-requester carry/flag state.
module adder_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic                    clock,
    input  logic                    nReset,
    input  logic [NUM_REQ-1:0]      reqValid,
    input  logic [NUM_REQ-1:0]      reqLock,
    input  logic [2*NUM_REQ-1:0]    reqOpcode,
    input  logic [4*NUM_REQ-1:0]    reqFlagMode,
    input  logic [32*NUM_REQ-1:0]   reqOperandA,
    input  logic [32*NUM_REQ-1:0]   reqOperandB,
    output logic [NUM_REQ-1:0]      reqReady,
    output logic [NUM_REQ-1:0]      respValid,
    output logic [31:0]             respResult,
    output logic                    respCarry,
    output logic                    respFlag,
    output logic [NUM_REQ-1:0]      carryState,
    output logic [NUM_REQ-1:0]      flagState,
    output logic [1:0]              adderOpcode,
    output logic [3:0]              adderFlagMode,
    output logic [31:0]             adderOperandA,
    output logic [31:0]             adderOperandB,
    output logic                    adderCarryIn,
    output logic                    adderFlagIn,
    input  logic [31:0]             adderResult,
    input  logic                    adderCarryOut,
    input  logic                    adderFlagOut
);

    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W-1:0]    ONE_ID     = ID_W'(1);
    localparam logic [3:0]         LOCK_LIMIT = 4'(MAX_LOCK);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    arb_state_t       state_r;
    arb_state_t       state_next_s;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  rr_ptr_next_s;
    logic [ID_W-1:0]  owner_r;
    logic [ID_W-1:0]  owner_next_s;
    logic [3:0]       lock_count_r;
    logic [3:0]       lock_count_next_s;
    logic             grant_s;
    logic [ID_W-1:0]  grant_id_s;

    logic [1:0]       sel_opcode_s;
    logic [3:0]       sel_flag_mode_s;
    logic [31:0]      sel_a_s;
    logic [31:0]      sel_b_s;

    logic             issue_valid_r;
    logic [ID_W-1:0]  issue_id_r;
    logic [1:0]       issue_opcode_r;
    logic [3:0]       issue_flag_mode_r;
    logic [31:0]      issue_a_r;
    logic [31:0]      issue_b_r;

    logic [NUM_REQ-1:0] carry_r;
    logic [NUM_REQ-1:0] flag_r;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        logic [ID_W-1:0] r;
        if (v == LAST_ID) begin
            r = '0;
        end else begin
            r = v + ONE_ID;
        end
        return r;
    endfunction

    // Arbitration and lock FSM: selects this cycle's grant and the next pointer/lock state.
    always_comb begin
        logic [ID_W-1:0] scan_v;
        logic [ID_W-1:0] arb_id_v;
        logic            found_v;
        scan_v            = rr_ptr_r;
        arb_id_v          = '0;
        found_v           = 1'b0;
        state_next_s      = state_r;
        rr_ptr_next_s     = rr_ptr_r;
        owner_next_s      = owner_r;
        lock_count_next_s = lock_count_r;
        grant_s           = 1'b0;
        grant_id_s        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_v && reqValid[scan_v]) begin
                found_v  = 1'b1;
                arb_id_v = scan_v;
            end else begin
                found_v  = found_v;
            end
            scan_v = wrap_inc(scan_v);
        end
        case (state_r)
            ARB: begin
                if (found_v) begin
                    grant_s       = 1'b1;
                    grant_id_s    = arb_id_v;
                    rr_ptr_next_s = wrap_inc(arb_id_v);
                    if (reqLock[arb_id_v] && (MAX_LOCK > 1)) begin
                        state_next_s      = LOCKED;
                        owner_next_s      = arb_id_v;
                        lock_count_next_s = 4'd1;
                    end else begin
                        state_next_s      = ARB;
                    end
                end else begin
                    state_next_s = ARB;
                end
            end
            LOCKED: begin
                if (reqValid[owner_r]) begin
                    grant_s           = 1'b1;
                    grant_id_s        = owner_r;
                    lock_count_next_s = lock_count_r + 4'd1;
                    if (!reqLock[owner_r] || ((lock_count_r + 4'd1) >= LOCK_LIMIT)) begin
                        state_next_s      = ARB;
                        lock_count_next_s = 4'd0;
                        rr_ptr_next_s     = wrap_inc(owner_r);
                    end else begin
                        state_next_s      = LOCKED;
                    end
                end else begin
                    // Owner dropped out: arbitrate now (rr_ptr already sits at owner+1), no new lock this round.
                    state_next_s      = ARB;
                    lock_count_next_s = 4'd0;
                    rr_ptr_next_s     = wrap_inc(owner_r);
                    if (found_v) begin
                        grant_s       = 1'b1;
                        grant_id_s    = arb_id_v;
                        rr_ptr_next_s = wrap_inc(arb_id_v);
                    end else begin
                        grant_s       = 1'b0;
                    end
                end
            end
            default: begin
                state_next_s      = ARB;
                lock_count_next_s = 4'd0;
            end
        endcase
    end

    // One-hot accept, suppressed while reset is held.
    always_comb begin
        if (grant_s && nReset) begin
            reqReady = ONE_HOT0 << grant_id_s;
        end else begin
            reqReady = '0;
        end
    end

    // Field mux for the granted requester.
    always_comb begin
        sel_opcode_s    = reqOpcode[{grant_id_s, 1'b0} +: 2];
        sel_flag_mode_s = reqFlagMode[{grant_id_s, 2'b00} +: 4];
        sel_a_s         = reqOperandA[{grant_id_s, 5'b00000} +: 32];
        sel_b_s         = reqOperandB[{grant_id_s, 5'b00000} +: 32];
    end

    // Adder drive from the issue stage; idle bus when the stage is empty.
    always_comb begin
        if (issue_valid_r) begin
            adderOpcode   = issue_opcode_r;
            adderFlagMode = issue_flag_mode_r;
            adderOperandA = issue_a_r;
            adderOperandB = issue_b_r;
            adderCarryIn  = carry_r[issue_id_r];
            adderFlagIn   = flag_r[issue_id_r];
        end else begin
            adderOpcode   = 2'b00;
            adderFlagMode = 4'b0000;
            adderOperandA = 32'd0;
            adderOperandB = 32'd0;
            adderCarryIn  = 1'b0;
            adderFlagIn   = 1'b0;
        end
    end

    // Arbiter state and issue register.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_r           <= ARB;
            rr_ptr_r          <= '0;
            owner_r           <= '0;
            lock_count_r      <= 4'd0;
            issue_valid_r     <= 1'b0;
            issue_id_r        <= '0;
            issue_opcode_r    <= 2'b00;
            issue_flag_mode_r <= 4'b0000;
            issue_a_r         <= 32'd0;
            issue_b_r         <= 32'd0;
        end else begin
            state_r       <= state_next_s;
            rr_ptr_r      <= rr_ptr_next_s;
            owner_r       <= owner_next_s;
            lock_count_r  <= lock_count_next_s;
            issue_valid_r <= grant_s;
            if (grant_s) begin
                issue_id_r        <= grant_id_s;
                issue_opcode_r    <= sel_opcode_s;
                issue_flag_mode_r <= sel_flag_mode_s;
                issue_a_r         <= sel_a_s;
                issue_b_r         <= sel_b_s;
            end
        end
    end

    // Response capture and per-requester carry/flag update.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            respValid  <= '0;
            respResult <= 32'd0;
            respCarry  <= 1'b0;
            respFlag   <= 1'b0;
            carry_r    <= '0;
            flag_r     <= '0;
        end else begin
            respValid <= issue_valid_r ? (ONE_HOT0 << issue_id_r) : '0;
            if (issue_valid_r) begin
                respResult          <= adderResult;
                respCarry           <= adderCarryOut;
                respFlag            <= adderFlagOut;
                flag_r[issue_id_r]  <= adderFlagOut;
                if (issue_opcode_r[1]) begin
                    carry_r[issue_id_r] <= adderCarryOut;
                end
            end
        end
    end

    assign carryState = carry_r;
    assign flagState  = flag_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter with a behavioural adder model attached.
module tb_adder_arbiter;

    localparam int N = 4;

    logic              clock = 1'b0;
    logic              nReset;
    logic [N-1:0]      reqValid;
    logic [N-1:0]      reqLock;
    logic [2*N-1:0]    reqOpcode;
    logic [4*N-1:0]    reqFlagMode;
    logic [32*N-1:0]   reqOperandA;
    logic [32*N-1:0]   reqOperandB;
    logic [N-1:0]      reqReady;
    logic [N-1:0]      respValid;
    logic [31:0]       respResult;
    logic              respCarry;
    logic              respFlag;
    logic [N-1:0]      carryState;
    logic [N-1:0]      flagState;
    logic [1:0]        adderOpcode;
    logic [3:0]        adderFlagMode;
    logic [31:0]       adderOperandA;
    logic [31:0]       adderOperandB;
    logic              adderCarryIn;
    logic              adderFlagIn;
    logic [31:0]       adderResult;
    logic              adderCarryOut;
    logic              adderFlagOut;

    int pass_cnt;
    int total_cnt;

    adder_arbiter #(.NUM_REQ(N), .MAX_LOCK(4)) dut (
        .clock(clock), .nReset(nReset),
        .reqValid(reqValid), .reqLock(reqLock), .reqOpcode(reqOpcode),
        .reqFlagMode(reqFlagMode), .reqOperandA(reqOperandA), .reqOperandB(reqOperandB),
        .reqReady(reqReady), .respValid(respValid), .respResult(respResult),
        .respCarry(respCarry), .respFlag(respFlag),
        .carryState(carryState), .flagState(flagState),
        .adderOpcode(adderOpcode), .adderFlagMode(adderFlagMode),
        .adderOperandA(adderOperandA), .adderOperandB(adderOperandB),
        .adderCarryIn(adderCarryIn), .adderFlagIn(adderFlagIn),
        .adderResult(adderResult), .adderCarryOut(adderCarryOut), .adderFlagOut(adderFlagOut)
    );

    always #5 clock = ~clock;

    // Adder: 10 add-with-carry, 11 subtract (carry = no borrow), 01 xor, 00 pass A; mode 0100 is A<B.
    always_comb begin
        logic [32:0] sum_v;
        case (adderOpcode)
            2'b10:   sum_v = {1'b0, adderOperandA} + {1'b0, adderOperandB} + {32'd0, adderCarryIn};
            2'b11:   sum_v = {1'b0, adderOperandA} + {1'b0, ~adderOperandB} + 33'd1;
            2'b01:   sum_v = {1'b1, adderOperandA ^ adderOperandB};
            default: sum_v = {1'b1, adderOperandA};
        endcase
        adderResult   = sum_v[31:0];
        adderCarryOut = sum_v[32];
        adderFlagOut  = (adderFlagMode == 4'b0100) ? (adderOperandA < adderOperandB) : adderFlagIn;
    end

    task automatic clear_reqs();
        reqValid    = '0;
        reqLock     = '0;
        reqOpcode   = '0;
        reqFlagMode = '0;
        reqOperandA = '0;
        reqOperandB = '0;
    endtask

    task automatic set_req(input int id, input logic v, input logic lk, input logic [1:0] op,
                           input logic [3:0] fm, input logic [31:0] a, input logic [31:0] b);
        reqValid[id]             = v;
        reqLock[id]              = lk;
        reqOpcode[id*2 +: 2]     = op;
        reqFlagMode[id*4 +: 4]   = fm;
        reqOperandA[id*32 +: 32] = a;
        reqOperandB[id*32 +: 32] = b;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        nReset = 1'b0;
        clear_reqs();
        next_cycle();
        next_cycle();
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        clear_reqs();
        next_cycle();
        next_cycle();
        @(negedge clock);
        total_cnt++;
        if (reqReady !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", reqReady); else pass_cnt++;
        total_cnt++;
        if (respValid !== 4'b0000) $display("FAIL reset_resp_valid: got %b want 0000", respValid); else pass_cnt++;
        total_cnt++;
        if (respResult !== 32'd0) $display("FAIL reset_result: got %h want 0", respResult); else pass_cnt++;
        total_cnt++;
        if ({carryState, flagState} !== 8'h00) $display("FAIL reset_state: got %b/%b want 0/0", carryState, flagState); else pass_cnt++;
        total_cnt++;
        if ({adderOpcode, adderOperandA} !== 34'd0) $display("FAIL reset_adder_bus: got %b/%h want 0/0", adderOpcode, adderOperandA); else pass_cnt++;
        @(posedge clock);
        #1;
        nReset = 1'b1;
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 1'b0, 2'b10, 4'b0000, 32'd5, 32'd7);
        @(negedge clock);
        total_cnt++;
        if (reqReady !== 4'b0001) $display("FAIL single_ready: got %b want 0001", reqReady); else pass_cnt++;
        next_cycle();
        clear_reqs();
        @(negedge clock);
        total_cnt++;
        if ({adderOpcode, adderOperandA, adderOperandB, adderCarryIn} !== {2'b10, 32'd5, 32'd7, 1'b0})
            $display("FAIL single_issue: got op=%b a=%0d b=%0d cin=%b want op=10 a=5 b=7 cin=0",
                     adderOpcode, adderOperandA, adderOperandB, adderCarryIn);
        else pass_cnt++;
        total_cnt++;
        if (respValid !== 4'b0000) $display("FAIL single_early_resp: got %b want 0000", respValid); else pass_cnt++;
        next_cycle();
        @(negedge clock);
        total_cnt++;
        if (respValid !== 4'b0001) $display("FAIL single_resp_valid: got %b want 0001", respValid); else pass_cnt++;
        total_cnt++;
        if (respResult !== 32'd12) $display("FAIL single_result: got %0d want 12", respResult); else pass_cnt++;
        total_cnt++;
        if (carryState !== 4'b0000) $display("FAIL single_carry: got %b want 0000", carryState); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_carry_chain();
        clear_reqs();
        set_req(1, 1'b1, 1'b1, 2'b10, 4'b0000, 32'hFFFF_FFFF, 32'd1);
        set_req(2, 1'b1, 1'b0, 2'b10, 4'b0000, 32'd1, 32'd2);
        @(negedge clock);
        total_cnt++;
        if (reqReady !== 4'b0010) $display("FAIL chain_first_grant: got %b want 0010", reqReady); else pass_cnt++;
        next_cycle();
        set_req(1, 1'b1, 1'b0, 2'b10, 4'b0000, 32'd0, 32'd0);
        @(negedge clock);
        total_cnt++;
        if (reqReady !== 4'b0010) $display("FAIL chain_locked_grant: got %b want 0010", reqReady); else pass_cnt++;
        next_cycle();
        set_req(1, 1'b0, 1'b0, 2'b00, 4'b0000, 32'd0, 32'd0);
        @(negedge clock);
        total_cnt++;
        if (reqReady !== 4'b0100) $display("FAIL chain_req2_after_lock: got %b want 0100", reqReady); else pass_cnt++;
        total_cnt++;
        if ({respValid, respResult} !== {4'b0010, 32'd0}) $display("FAIL chain_first_resp: got %b/%h want 0010/0", respValid, respResult); else pass_cnt++;
        total_cnt++;
        if (carryState[1] !== 1'b1) $display("FAIL chain_carry_set: got %b want 1", carryState[1]); else pass_cnt++;
        total_cnt++;
        if (adderCarryIn !== 1'b1) $display("FAIL chain_carry_in: got %b want 1", adderCarryIn); else pass_cnt++;
        next_cycle();
        clear_reqs();
        @(negedge clock);
        total_cnt++;
        if ({respValid, respResult} !== {4'b0010, 32'd1}) $display("FAIL chain_second_resp: got %b/%h want 0010/1", respValid, respResult); else pass_cnt++;
        next_cycle();
        @(negedge clock);
        total_cnt++;
        if ({respValid, respResult} !== {4'b0100, 32'd3}) $display("FAIL chain_req2_resp: got %b/%h want 0100/3", respValid, respResult); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_v;
        logic [31:0] exp_w;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 2'b00, 4'b0000, 32'h100 + 32'(i), 32'd0);
            end else begin
                clear_reqs();
            end
            @(negedge clock);
            if (k < 8) begin
                exp_v = 4'b0001 << (k % 4);
                total_cnt++;
                if (reqReady !== exp_v) $display("FAIL rr_grant[%0d]: got %b want %b", k, reqReady, exp_v); else pass_cnt++;
            end
            if (k >= 2) begin
                exp_v = 4'b0001 << ((k - 2) % 4);
                exp_w = 32'h100 + 32'((k - 2) % 4);
                total_cnt++;
                if ({respValid, respResult} !== {exp_v, exp_w})
                    $display("FAIL rr_resp[%0d]: got %b/%h want %b/%h", k, respValid, respResult, exp_v, exp_w);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (respValid !== 4'b0000) $display("FAIL rr_no_resp[%0d]: got %b want 0000", k, respValid); else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_lock_limit();
        logic [3:0] exp_seq [6];
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100};
        for (int i = 0; i < N; i++) set_req(i, 1'b1, (i == 0), 2'b00, 4'b0000, 32'h200 + 32'(i), 32'd0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            total_cnt++;
            if (reqReady !== exp_seq[j]) $display("FAIL lock_grant[%0d]: got %b want %b", j, reqReady, exp_seq[j]); else pass_cnt++;
            if (j == 5) begin
                total_cnt++;
                if (respValid !== 4'b0001) $display("FAIL lock_resp: got %b want 0001", respValid); else pass_cnt++;
            end
            next_cycle();
        end
        clear_reqs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_isolated_state();
        set_req(0, 1'b1, 1'b0, 2'b00, 4'b0100, 32'd3, 32'd9);
        @(negedge clock);
        total_cnt++;
        if (reqReady !== 4'b0001) $display("FAIL iso_grant0: got %b want 0001", reqReady); else pass_cnt++;
        next_cycle();
        clear_reqs();
        set_req(3, 1'b1, 1'b0, 2'b00, 4'b0000, 32'h55, 32'd0);
        @(negedge clock);
        total_cnt++;
        if (reqReady !== 4'b1000) $display("FAIL iso_grant3: got %b want 1000", reqReady); else pass_cnt++;
        total_cnt++;
        if ({adderFlagMode, adderFlagIn} !== {4'b0100, 1'b0}) $display("FAIL iso_cmp_issue: got %b/%b want 0100/0", adderFlagMode, adderFlagIn); else pass_cnt++;
        next_cycle();
        clear_reqs();
        set_req(2, 1'b1, 1'b0, 2'b11, 4'b0000, 32'd9, 32'd3);
        @(negedge clock);
        total_cnt++;
        if ({respValid, respFlag, flagState} !== {4'b0001, 1'b1, 4'b0001})
            $display("FAIL iso_cmp_resp: got %b/%b/%b want 0001/1/0001", respValid, respFlag, flagState);
        else pass_cnt++;
        total_cnt++;
        if (adderFlagIn !== 1'b0) $display("FAIL iso_req3_flag_in: got %b want 0", adderFlagIn); else pass_cnt++;
        next_cycle();
        clear_reqs();
        @(negedge clock);
        total_cnt++;
        if ({respValid, respFlag, respResult} !== {4'b1000, 1'b0, 32'h55})
            $display("FAIL iso_req3_resp: got %b/%b/%h want 1000/0/55", respValid, respFlag, respResult);
        else pass_cnt++;
        total_cnt++;
        if ({adderOpcode, adderCarryIn} !== {2'b11, 1'b0}) $display("FAIL iso_sub_issue: got %b/%b want 11/0", adderOpcode, adderCarryIn); else pass_cnt++;
        next_cycle();
        @(negedge clock);
        total_cnt++;
        if ({respValid, respResult, respCarry} !== {4'b0100, 32'd6, 1'b1})
            $display("FAIL iso_sub_resp: got %b/%0d/%b want 0100/6/1", respValid, respResult, respCarry);
        else pass_cnt++;
        total_cnt++;
        if ({carryState, flagState} !== {4'b0100, 4'b0001})
            $display("FAIL iso_state: got %b/%b want 0100/0001", carryState, flagState);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_mid_lock();
        clear_reqs();
        set_req(1, 1'b1, 1'b1, 2'b10, 4'b0000, 32'd10, 32'd20);
        set_req(2, 1'b1, 1'b0, 2'b00, 4'b0000, 32'd7, 32'd0);
        @(negedge clock);
        total_cnt++;
        if (reqReady !== 4'b0010) $display("FAIL rst_lock_grant: got %b want 0010", reqReady); else pass_cnt++;
        next_cycle();
        @(negedge clock);
        total_cnt++;
        if (reqReady !== 4'b0010) $display("FAIL rst_lock_hold: got %b want 0010", reqReady); else pass_cnt++;
        next_cycle();
        @(negedge clock);
        total_cnt++;
        if (adderOperandA !== 32'd10) $display("FAIL rst_issue_busy: got %0d want 10", adderOperandA); else pass_cnt++;
        #1;
        nReset = 1'b0;
        #1;
        total_cnt++;
        if ({respValid, reqReady} !== 8'h00) $display("FAIL rst_async_clear: got %b/%b want 0000/0000", respValid, reqReady); else pass_cnt++;
        total_cnt++;
        if ({carryState, flagState, adderOperandA} !== 40'd0)
            $display("FAIL rst_state_clear: got %b/%b/%h want 0/0/0", carryState, flagState, adderOperandA);
        else pass_cnt++;
        next_cycle();
        @(negedge clock);
        total_cnt++;
        if (respValid !== 4'b0000) $display("FAIL rst_no_resp: got %b want 0000", respValid); else pass_cnt++;
        next_cycle();
        nReset = 1'b1;
        set_req(0, 1'b1, 1'b0, 2'b00, 4'b0000, 32'd1, 32'd0);
        set_req(1, 1'b1, 1'b0, 2'b00, 4'b0000, 32'd2, 32'd0);
        @(negedge clock);
        total_cnt++;
        if (reqReady !== 4'b0001) $display("FAIL rst_restart_grant: got %b want 0001", reqReady); else pass_cnt++;
        next_cycle();
        clear_reqs();
        @(negedge clock);
        total_cnt++;
        if (respValid !== 4'b0000) $display("FAIL rst_discarded: got %b want 0000", respValid); else pass_cnt++;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_single();
        test_carry_chain();
        test_round_robin();
        test_lock_limit();
        test_isolated_state();
        test_reset_mid_lock();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 32-bit adder/comparator instance between NUM_REQ requesters (ALU, address generation, debug unit) using round-robin arbitration with a bounded lock for multi-word carry chains.
- Keeps a private carry bit and flag bit per requester, so interleaved add-with-carry sequences from different requesters do not corrupt each other.
- Sits between the requesters and the adder. Drives the adder's opcode, flagMode, operands, carryIn and flagIn. Registers the adder's result, carryOut and flagOut.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- MAX_LOCK, 4, maximum number of consecutive grants one requester may hold through reqLock; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- reqValid  in  NUM_REQ  per-requester request.
- reqLock  in  NUM_REQ  requester wants the next grant (carry chain).
- reqOpcode  in  2*NUM_REQ  adder opcode; requester i uses bits [2i+1:2i].
- reqFlagMode  in  4*NUM_REQ  compare mode; requester i uses bits [4i+3:4i].
- reqOperandA  in  32*NUM_REQ  operand A, flattened per requester.
- reqOperandB  in  32*NUM_REQ  operand B, flattened per requester.
- reqReady  out  NUM_REQ  one-hot accept (grant) for this cycle.
- respValid  out  NUM_REQ  one-hot, one-cycle response strobe.
- respResult  out  32  result, shared by all requesters; qualified by respValid.
- respCarry  out  1  carryOut of the responded op.
- respFlag  out  1  flagOut of the responded op.
- carryState  out  NUM_REQ  current per-requester carry registers.
- flagState  out  NUM_REQ  current per-requester flag registers.
- adderOpcode  out  2  to adder.
- adderFlagMode  out  4  to adder.
- adderOperandA  out  32  to adder.
- adderOperandB  out  32  to adder.
- adderCarryIn  out  1  to adder.
- adderFlagIn  out  1  to adder.
- adderResult  in  32  from adder.
- adderCarryOut  in  1  from adder.
- adderFlagOut  in  1  from adder.

Behaviour:
- Reset (nReset=0, asynchronous): all registers cleared.
  - reqReady=0, respValid=0, respResult=0, respCarry=0, respFlag=0.
  - carryState=0, flagState=0.
  - Issue stage invalid. Round-robin pointer set so requester 0 has highest priority. FSM in ARB with lockCount=0.
  - Reset mid-operation discards the in-flight issue and any pending response; no respValid is produced for it.
- Accept: reqReady[i] is combinational, at most one bit set, never set unless reqValid[i]=1. A transfer occurs on an edge where reqValid[i]&reqReady[i]=1.
  - Requesters hold all req* fields stable until accepted.
  - One accept per cycle; the issue stage is always free, so throughput is 1 op/cycle.
- Pipeline, for an op accepted at the end of cycle T:
  - The issue register holds the op through cycle T+1.
  - During T+1 the adder* outputs are driven from the issue register. adderCarryIn=carryState[id] and adderFlagIn=flagState[id], where id is the issuing requester.
  - At the end of T+1, respResult, respCarry and respFlag are registered and respValid[id]=1 during T+2.
  - Fixed latency is 2 cycles from accept to response.
  - When the issue stage is invalid, adder* outputs are 0 and no response is produced.
- Per-requester state, updated at the same edge the response is registered:
  - flagState[id] <= adderFlagOut. Non-compare flagModes return flagIn, so the flag is unchanged in that case.
  - carryState[id] <= adderCarryOut when opcode[1]=1; otherwise it holds.
  - A back-to-back op from the same requester issues in the cycle after this edge and sees the updated carry. No forwarding path is required.
- FSM:
  - ARB: grant the first requesting index at or after rrPtr, wrapping modulo NUM_REQ. On accept, set rrPtr=(granted+1) mod NUM_REQ.
    - If reqLock of the granted requester is 1 and MAX_LOCK>1, go to LOCKED with owner=granted and lockCount=1.
  - LOCKED: if reqValid[owner]=1, grant the owner regardless of others and increment lockCount.
    - Exit to ARB on any of: the accepted request has reqLock=0, lockCount reaches MAX_LOCK, or reqValid[owner]=0. On the reqValid[owner]=0 exit, normal arbitration runs in that same cycle, with no bubble.
    - rrPtr is not updated while LOCKED; it is set to owner+1 on exit.
- Simultaneous events: several requests in ARB resolve by round-robin only. A lock request arriving in the cycle a lock expires is ignored for one arbitration round.

Test Plan:
- Reset, then single request: req0 opcode=10, A=5, B=7, carry=0, accepted cycle 1 -> respValid[0] in cycle 3, respResult=12, carryState[0]=0.
- Carry chain: req1 locked pair. First op A=FFFFFFFF, B=1, opcode=10 -> result 0, carryState[1]=1. Second op A=0, B=0, opcode=10 -> result 1. req2 requesting throughout is granted only after the lock drops.
- Round-robin fairness: all 4 requesters valid continuously -> grant order 0,1,2,3,0,…; respValid one-hot every cycle from cycle 3.
- Lock limit: MAX_LOCK=4, req0 holds reqLock=1 with others valid -> exactly 4 consecutive grants to req0, then req1 is granted.
- Isolated state: req0 compare flagMode=0100, A=3, B=9 -> flagState[0]=1, and a following req3 op sees adderFlagIn=0. Subtract opcode=11, A=9, B=3 -> result 6, carryState=1.
- Asynchronous reset asserted mid-lock with an op in the issue stage -> no respValid; all state registers read 0; grant restarts at requester 0.
